spi_master: RTL

Clock-divided SPI master. It transmits one WIDTH-bit word on MOSI while capturing one word from MISO, and drives SCK and a single active-low slave select. It is the initiator-side counterpart of the team's spi_slave, with the same CPOL/CPHA/WIDTH/LSB parameter meanings so that a matched pair interoperates. Everything runs in the i_clk domain behind a start/busy/done handshake.

---
 rtl/spi_master.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: clock-divided SPI master with start/busy/done handshake and one active-low select.
module spi_master #(
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  parameter int WIDTH   = 8,
  parameter bit LSB     = 1'b0,
  parameter int CLK_DIV = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_sck,
  output logic             o_mosi,
  output logic             o_ss_n,
  input  logic             i_miso,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_busy,
  output logic             o_rx_int,
  output logic [WIDTH-1:0] o_rx_data
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int EW = $clog2(2 * WIDTH);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [DW-1:0] div, div_n;
  logic [EW-1:0] edges, edges_n;
  logic [WIDTH-1:0] tx, tx_n, rx, rx_n, rx_data_n;
  logic sck_n, mosi_n, rx_int_n, miso_s1, miso_s2;
  logic tick, edge_ev, lead, sample, shift, last, active;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return LSB ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return LSB ? w >> 1 : w << 1;
  endfunction

  assign tick    = div == DW'(CLK_DIV - 1);
  assign active  = state inside {SETUP, XFER, HOLD};
  assign last    = state == XFER && edges == EW'(2 * WIDTH - 1);
  // The first SCK edge is the SETUP->XFER transition; edges then counts edges already made.
  assign edge_ev = tick && (state == XFER || (state == SETUP && edges[0]));
  assign lead    = state == SETUP || !edges[0];
  assign sample  = edge_ev && (lead ^ CPHA);
  assign shift   = edge_ev && !(lead ^ CPHA) && !last;
  assign o_busy  = state != IDLE;
  assign o_ss_n  = !active;

  always_comb begin
    state_n   = state;
    div_n     = (state == IDLE || tick) ? '0 : div + 1'b1;
    edges_n   = edges;
    sck_n     = edge_ev ? !o_sck : o_sck;
    mosi_n    = shift ? head(tx) : o_mosi;
    tx_n      = shift ? adv(tx) : tx;
    rx_n      = sample ? (LSB ? {miso_s2, rx[WIDTH-1:1]} : {rx[WIDTH-2:0], miso_s2}) : rx;
    rx_int_n  = 1'b0;
    rx_data_n = o_rx_data;
    case (state)
      IDLE: if (i_start) begin
        state_n = SETUP;
        tx_n    = CPHA ? i_tx_data : adv(i_tx_data);
        mosi_n  = CPHA ? 1'b0 : head(i_tx_data);
      end
      SETUP: if (tick) begin
        state_n = edges[0] ? XFER : SETUP;
        edges_n = EW'(1);
      end
      XFER: if (tick) begin
        state_n = last ? HOLD : XFER;
        edges_n = last ? '0 : edges + 1'b1;
      end
      HOLD: if (tick) begin
        state_n   = GAP;
        rx_int_n  = 1'b1;
        rx_data_n = rx;
        mosi_n    = 1'b0;
      end
      GAP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (i_abort && active) begin
      state_n   = GAP;
      div_n     = '0;
      edges_n   = '0;
      sck_n     = CPOL;
      mosi_n    = 1'b0;
      rx_int_n  = 1'b0;
      rx_data_n = o_rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      div       <= '0;
      edges     <= '0;
      o_sck     <= CPOL;
      o_mosi    <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      o_rx_int  <= 1'b0;
      o_rx_data <= '0;
      miso_s1   <= 1'b0;
      miso_s2   <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= div_n;
      edges     <= edges_n;
      o_sck     <= sck_n;
      o_mosi    <= mosi_n;
      tx        <= tx_n;
      rx        <= rx_n;
      o_rx_int  <= rx_int_n;
      o_rx_data <= rx_data_n;
      miso_s1   <= i_miso;
      miso_s2   <= miso_s1;
    end
  end
endmodule
